// File: rtl/key_event_decoder.sv
// ---------------------------------------------------------------------------
// key_event_decoder
//
// Classifies debounced key gestures into one-cycle event pulses for the
// water-level control FSM. Runs on the 1 kHz system tick, so one clock
// cycle is one millisecond and every timing parameter is in cycles.
//
// Gestures:
//   short press  : press, release, no second press within DOUBLE_GAP_MS
//   double click : press, release, second press within DOUBLE_GAP_MS
//   long press   : key held LONG_MS cycles after the press pulse
//   auto-repeat  : every REPEAT_MS cycles while still held after long press
//
// Parameters:
//   LONG_MS       cycles held after press before long_evt
//   DOUBLE_GAP_MS max cycles after release for a second press to count
//   REPEAT_MS     repeat_evt period while held after long_evt
//   CNT_W         counter width; 2**CNT_W must exceed the largest of the
//                 three timing parameters
//
// Ports:
//   clk         in   system clock (1 kHz tick)
//   reset       in   synchronous, active-high reset
//   stable_flag in   debounced key level, 1 = held
//   press       in   one-cycle pulse on debounced press edge
//   short_evt   out  one-cycle pulse: single short press confirmed
//   double_evt  out  one-cycle pulse: double click
//   long_evt    out  one-cycle pulse: long-press threshold reached
//   repeat_evt  out  one-cycle pulse: auto-repeat during long hold
//   busy        out  high whenever a gesture is in progress (state != IDLE)
//
// All outputs are registered; at most one event pulse is high per cycle.
// ---------------------------------------------------------------------------
module key_event_decoder #(
  parameter int LONG_MS       = 1000,
  parameter int DOUBLE_GAP_MS = 300,
  parameter int REPEAT_MS     = 200,
  parameter int CNT_W         = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic stable_flag,
  input  logic press,
  output logic short_evt,
  output logic double_evt,
  output logic long_evt,
  output logic repeat_evt,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED1,
    WAIT_SECOND,
    PRESSED2,
    LONG_HELD
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so reaching
  // N-1 on a sampled edge means N cycles have elapsed since entry.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // NOTE: state and registered outputs live in one clocked block and are
  // assigned with non-blocking (<=) so every branch reads the pre-edge
  // values of state and cnt, giving true flip-flop semantics.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Aborts any gesture in flight without emitting an event.
      state      <= IDLE;
      cnt        <= '0;
      short_evt  <= 1'b0;
      double_evt <= 1'b0;
      long_evt   <= 1'b0;
      repeat_evt <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Event outputs are pulses: cleared every cycle unless a branch
      // below fires one.
      short_evt  <= 1'b0;
      double_evt <= 1'b0;
      long_evt   <= 1'b0;
      repeat_evt <= 1'b0;

      case (state)
        IDLE: begin
          // Only the press pulse starts a gesture; a stuck-high level
          // (e.g. after a reset mid-hold) must not.
          if (press) begin
            state <= PRESSED1;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        PRESSED1: begin
          // Release is tested first so a release on the threshold cycle
          // becomes a short-press candidate rather than a long press.
          if (!stable_flag) begin
            state <= WAIT_SECOND;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            long_evt <= 1'b1;
            state    <= LONG_HELD;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_SECOND: begin
          // Press beats timeout when both land on the same cycle.
          if (press) begin
            double_evt <= 1'b1;
            state      <= PRESSED2;
            cnt        <= '0;
          end else if (cnt == GAP_LAST) begin
            short_evt <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PRESSED2: begin
          // Second press of a double click is never timed; just wait for
          // the key to come up. Stray press pulses have no effect.
          if (!stable_flag) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end

        LONG_HELD: begin
          if (!stable_flag) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == REPEAT_LAST) begin
            repeat_evt <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_event_decoder
//
// Directed gestures drive key_event_decoder; each gesture pushes the events
// it must produce (kind + clock edge index) into a scoreboard queue. A
// negedge monitor pops an entry whenever the DUT raises any event and
// compares kind and edge; an event with nothing pending is an error.
// ---------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam int LONG_MS       = 1000;
  localparam int DOUBLE_GAP_MS = 300;
  localparam int REPEAT_MS     = 200;
  localparam int CNT_W         = 12;

  typedef enum int {EV_SHORT, EV_DOUBLE, EV_LONG, EV_REPEAT} ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stable_flag = 1'b0;
  logic press = 1'b0;
  logic short_evt, double_evt, long_evt, repeat_evt, busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  exp_t exp_q[$];

  key_event_decoder #(
    .LONG_MS      (LONG_MS),
    .DOUBLE_GAP_MS(DOUBLE_GAP_MS),
    .REPEAT_MS    (REPEAT_MS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stable_flag(stable_flag),
    .press      (press),
    .short_evt  (short_evt),
    .double_evt (double_evt),
    .long_evt   (long_evt),
    .repeat_evt (repeat_evt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Edge index: after rising edge n settles, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    int       n;
    ev_kind_t k;
    exp_t     e;
    if (mon_on) begin
      n = int'(short_evt) + int'(double_evt) + int'(long_evt) + int'(repeat_evt);
      if (n > 1) begin
        check("one_event_per_cycle", n, 1);
      end else if (n == 1) begin
        if (short_evt)       k = EV_SHORT;
        else if (double_evt) k = EV_DOUBLE;
        else if (long_evt)   k = EV_LONG;
        else                 k = EV_REPEAT;
        check($sformatf("event_pending_%s", k.name()), int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("event_kind_%s", e.kind.name()), int'(k), int'(e.kind));
          check($sformatf("event_edge_%s", e.kind.name()), cyc, e.edge_n);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic p, input logic f);
    press       = p;
    stable_flag = f;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, input logic f);
    repeat (n) step(1'b0, f);
  endtask

  task automatic expect_ev(input ev_kind_t k, input int edge_n);
    exp_t e;
    e.kind   = k;
    e.edge_n = edge_n;
    exp_q.push_back(e);
  endtask

  // Idle the inputs until every expected event has appeared, bounded.
  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step(1'b0, 1'b0);
      i++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int r;

    // ---- Reset held 10 cycles with inputs toggling ----
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(logic'(i % 2), logic'((i / 2) % 2));
      check("reset_busy", int'(busy), 0);
      check("reset_events", int'({short_evt, double_evt, long_evt, repeat_evt}), 0);
    end
    reset = 1'b0;
    hold(3, 1'b0);
    check("post_reset_busy", int'(busy), 0);

    // ---- Short press: held 100, released, no second press ----
    step(1'b1, 1'b1);
    p = cyc;
    check("short_busy_after_press", int'(busy), 1);
    expect_ev(EV_SHORT, p + 100 + DOUBLE_GAP_MS);
    hold(99, 1'b1);
    step(1'b0, 1'b0);
    check("short_busy_in_gap", int'(busy), 1);
    drain("short", 400);
    check("short_busy_after", int'(busy), 0);

    // ---- Double click: held 100, low 20, press, stray press, release ----
    step(1'b1, 1'b1);
    p = cyc;
    expect_ev(EV_DOUBLE, p + 120);
    hold(99, 1'b1);
    step(1'b0, 1'b0);
    hold(19, 1'b0);
    step(1'b1, 1'b1);
    hold(49, 1'b1);
    step(1'b1, 1'b1);            // ignored in PRESSED2
    hold(49, 1'b1);
    check("double_busy_held", int'(busy), 1);
    step(1'b0, 1'b0);
    check("double_busy_drop", int'(busy), 0);
    hold(400, 1'b0);
    check("double_pending", exp_q.size(), 0);

    // ---- Long press with repeats, stray presses while held ----
    step(1'b1, 1'b1);
    p = cyc;
    expect_ev(EV_LONG,   p + LONG_MS);
    expect_ev(EV_REPEAT, p + LONG_MS + REPEAT_MS);
    expect_ev(EV_REPEAT, p + LONG_MS + 2 * REPEAT_MS);
    expect_ev(EV_REPEAT, p + LONG_MS + 3 * REPEAT_MS);
    hold(49, 1'b1);
    step(1'b1, 1'b1);            // ignored in PRESSED1
    hold(1049, 1'b1);
    step(1'b1, 1'b1);            // ignored in LONG_HELD
    hold(549, 1'b1);
    step(1'b0, 1'b0);            // release at edge p+1650
    check("long_release_edge", cyc - p, 1650);
    check("long_busy_drop", int'(busy), 0);
    hold(500, 1'b0);
    check("long_pending", exp_q.size(), 0);

    // ---- Second press exactly on the last gap cycle: double only ----
    step(1'b1, 1'b1);
    p = cyc;
    hold(99, 1'b1);
    step(1'b0, 1'b0);
    r = cyc;
    expect_ev(EV_DOUBLE, r + DOUBLE_GAP_MS);
    hold(DOUBLE_GAP_MS - 1, 1'b0);
    step(1'b1, 1'b1);
    check("gap_edge_press_edge", cyc - r, DOUBLE_GAP_MS);
    hold(9, 1'b1);
    step(1'b0, 1'b0);
    check("gap_edge_busy_drop", int'(busy), 0);
    hold(400, 1'b0);
    check("gap_edge_pending", exp_q.size(), 0);

    // ---- Release exactly on the long threshold: short, not long ----
    step(1'b1, 1'b1);
    p = cyc;
    expect_ev(EV_SHORT, p + LONG_MS + DOUBLE_GAP_MS);
    hold(LONG_MS - 1, 1'b1);
    step(1'b0, 1'b0);
    check("long_edge_release_edge", cyc - p, LONG_MS);
    check("long_edge_busy", int'(busy), 1);
    drain("long_edge", 400);
    check("long_edge_busy_after", int'(busy), 0);

    // ---- Reset mid-gesture: nothing ever emitted ----
    step(1'b1, 1'b1);
    hold(149, 1'b1);
    reset = 1'b1;
    hold(2, 1'b1);
    check("abort_busy_in_reset", int'(busy), 0);
    reset = 1'b0;
    hold(148, 1'b1);
    check("abort_level_no_start", int'(busy), 0);
    step(1'b0, 1'b0);
    hold(1200, 1'b0);
    check("abort_busy_end", int'(busy), 0);
    check("abort_pending", exp_q.size(), 0);

    // ---- First press after the aborted gesture still works ----
    step(1'b1, 1'b1);
    p = cyc;
    expect_ev(EV_SHORT, p + 10 + DOUBLE_GAP_MS);
    hold(9, 1'b1);
    step(1'b0, 1'b0);
    drain("recover", 400);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
